// File: rtl/dvsd_div_pkg.sv
// Shared definitions for the 16/8 restoring divider: widths, FSM states, error code.
package dvsd_div_pkg;

    // Default divisor/quotient/remainder width; dividend is twice this wide.
    localparam int DW_DEF = 8;

    // Quotient value reported when the result is not meaningful.
    localparam logic [DW_DEF-1:0] ERR_Q_DEF = {DW_DEF{1'b1}};

    // Step counter width for the default width.
    localparam int CNT_W_DEF = $clog2(DW_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/compressor3to2.sv
// 3:2 compressor (full adder) cell: three equally weighted bits in, sum and carry out.
module compressor3to2 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/dvsd_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial
// remainder and keep the difference only when it did not borrow.
module dvsd_div_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   r_prime,   // partial remainder after shifting in the next dividend bit
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] r_next,    // R < divisor afterwards, so the top bit is always 0
    output logic          qbit
);

    logic [DW:0]   divisor_inv;
    logic [DW:0]   diff;
    logic [DW+1:0] carry;
    logic          unused_diff_top;

    // A + ~B + 1 computes A - B; a carry out of the top bit means no borrow, i.e. A >= B.
    assign divisor_inv = ~{1'b0, divisor};
    assign carry[0]    = 1'b1;

    generate
        for (genvar gi = 0; gi <= DW; gi++) begin : g_sub
            compressor3to2 u_cell (
                .a     (r_prime[gi]),
                .b     (divisor_inv[gi]),
                .cin   (carry[gi]),
                .sum   (diff[gi]),
                .carry (carry[gi+1])
            );
        end
    endgenerate

    // When the subtraction succeeds the difference is below the divisor, so its top bit is zero.
    assign unused_diff_top = diff[DW];

    assign qbit   = carry[DW+1];
    assign r_next = qbit ? diff[DW-1:0] : r_prime[DW-1:0];

endmodule

// File: rtl/dvsd_16d8_div.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit
// per clock, valid/ready handshakes on both sides, divide-by-zero and overflow flags.
module dvsd_16d8_div
    import dvsd_div_pkg::*;
#(
    parameter int            DW    = DW_DEF,
    parameter logic [DW-1:0] ERR_Q = {DW{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            ovf
);

    localparam int CW = cnt_width(DW);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;          // partial remainder; its (DW+1)th bit is always 0
    logic [DW-1:0]   shift_q, shift_d;      // dividend low half out at MSB, quotient bits in at LSB
    logic [DW-1:0]   divisor_q, divisor_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;

    logic [DW:0]     r_prime;
    logic [DW-1:0]   r_next;
    logic            qbit;
    logic [DW-1:0]   shift_after;

    assign r_prime     = {rem_q, shift_q[DW-1]};
    assign shift_after = {shift_q[DW-2:0], qbit};

    dvsd_div_step #(.DW(DW)) u_step (
        .r_prime (r_prime),
        .divisor (divisor_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // Next-state, datapath and result-register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    cnt_d      = '0;
                    divisor_d  = divisor;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        div_zero_d  = 1'b1;
                        quotient_d  = ERR_Q;
                        remainder_d = dividend[DW-1:0];
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        // Quotient would need more than DW bits.
                        state_d     = DONE;
                        ovf_d       = 1'b1;
                        quotient_d  = ERR_Q;
                        remainder_d = dividend[DW-1:0];
                    end else begin
                        state_d = RUN;
                        rem_d   = dividend[2*DW-1:DW];
                        shift_d = dividend[DW-1:0];
                    end
                end
            end

            RUN: begin
                rem_d   = r_next;
                shift_d = shift_after;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d     = DONE;
                    quotient_d  = shift_after;
                    remainder_d = r_next;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dvsd_16d8_div.sv
// Directed and random checks for the sequential 16/8 restoring divider.
module tb_dvsd_16d8_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q, got_r;
    logic       got_dz, got_ov;
    int         got_lat;

    dvsd_16d8_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result, optionally stall the consumer, then retire it.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        got_lat  = 1;
        while (!out_valid && got_lat < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            got_lat++;
        end
        got_q  = quotient;
        got_r  = remainder;
        got_dz = div_zero;
        got_ov = ovf;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_quotient", 32'(quotient), 32'(got_q));
            check("hold_remainder", 32'(remainder), 32'(got_r));
            check("hold_flags", {30'd0, div_zero, ovf}, {30'd0, got_dz, got_ov});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_out_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic expect_res(input string tag, input logic [15:0] a, input logic [7:0] b,
                              input logic [7:0] eq, input logic [7:0] er,
                              input logic edz, input logic eov, input int elat, input bit verbose);
        check({tag, "_latency"}, 32'(got_lat), 32'(elat));
        check({tag, "_quotient"}, 32'(got_q), 32'(eq));
        check({tag, "_remainder"}, 32'(got_r), 32'(er));
        check({tag, "_div_zero"}, 32'(got_dz), 32'(edz));
        check({tag, "_ovf"}, 32'(got_ov), 32'(eov));
        if (verbose)
            $display("%s: %04h / %02h -> q=%02h r=%02h dz=%0d ovf=%0d lat=%0d",
                     tag, a, b, got_q, got_r, got_dz, got_ov, got_lat);
    endtask

    initial begin
        logic [15:0] a16;
        logic [7:0]  a8, b8, eq, er;
        logic        edz, eov;
        int          elat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_flags", {30'd0, div_zero, ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        $display("reset: out_valid=%0d in_ready=%0d q=%02h r=%02h", out_valid, in_ready, quotient, remainder);

        // 1. largest product of two 8-bit values
        run_op(16'hFE01, 8'hFF, 0);
        expect_res("t1", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9, 1'b1);

        // 2. 1000 / 7
        run_op(16'h03E8, 8'h07, 0);
        expect_res("t2", 16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9, 1'b1);

        // 3. divide by zero
        run_op(16'h1234, 8'h00, 0);
        expect_res("t3", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1, 1'b1);

        // 4. quotient overflow at the boundary (high half equals divisor)
        run_op(16'h0800, 8'h08, 0);
        expect_res("t4", 16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1'b1);

        // 5. backpressure for 5 cycles in DONE
        run_op(16'h03E8, 8'h07, 5);
        expect_res("t5", 16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9, 1'b1);

        // 6. reset in the middle of RUN, then a fresh operation
        dividend = 16'h03E8;
        divisor  = 8'h07;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t6_running", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_quotient", 32'(quotient), 32'd0);
        check("t6_rst_remainder", 32'(remainder), 32'd0);
        check("t6_rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        $display("t6: reset mid-run -> out_valid=%0d q=%02h r=%02h", out_valid, quotient, remainder);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'h0064, 8'h0A, 0);
        expect_res("t6", 16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 9, 1'b1);

        // Products a*b must divide back to a with zero remainder.
        for (int n = 0; n < 1500; n++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(1, 255));
            a16 = 16'(a8) * 16'(b8);
            run_op(a16, b8, 0);
            expect_res("prod", a16, b8, a8, 8'h00, 1'b0, 1'b0, 9, 1'b0);
        end
        $display("product sweep done: %0d checks so far, %0d errors", checks, errors);

        // Arbitrary operands against a reference model.
        for (int n = 0; n < 1500; n++) begin
            a16 = 16'($urandom);
            b8  = (n % 37 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            if (b8 == 8'h00) begin
                eq = 8'hFF; er = a16[7:0]; edz = 1'b1; eov = 1'b0; elat = 1;
            end else if (a16[15:8] >= b8) begin
                eq = 8'hFF; er = a16[7:0]; edz = 1'b0; eov = 1'b1; elat = 1;
            end else begin
                eq = 8'(a16 / 16'(b8)); er = 8'(a16 % 16'(b8)); edz = 1'b0; eov = 1'b0; elat = 9;
            end
            run_op(a16, b8, n % 3);
            expect_res("rand", a16, b8, eq, er, edz, eov, elat, 1'b0);
        end
        $display("random sweep done: %0d checks so far, %0d errors", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
